decoder_stream: RTL

DECODER_STREAM -- requirements
Module: decoder_stream

---
 rtl/decoder_stream.sv | 109 ++++++++++
 1 files changed

// File: rtl/decoder_stream.sv
// rtl/decoder_stream.sv - one-hot/thermometer code decoder with 2-entry result buffer and error counter
module decoder_stream #(
    parameter int IN_W    = 3,
    parameter int NUM_OUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_code,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_lines,
    output logic               out_err,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   err_cnt
);

    // Entry layout: {err, lines}
    localparam int EW = NUM_OUT + 1;

    logic [1:0]    count, count_nxt;
    logic [EW-1:0] head, head_nxt;
    logic [EW-1:0] tail, tail_nxt;
    logic [EW-1:0] dec_entry;
    logic [31:0]   code_w;
    logic          dec_err;
    logic          push, pop;

    assign code_w = 32'(in_code);
    assign push   = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_comb begin
        dec_err   = (code_w >= 32'(NUM_OUT));
        dec_entry = '0;
        dec_entry[NUM_OUT] = dec_err;
        for (int i = 0; i < NUM_OUT; i++) begin
            dec_entry[i] = !dec_err &&
                           (in_mode ? (32'(i) <= code_w) : (32'(i) == code_w));
        end
    end

    // State register: occupancy, entries, and a registered in_ready
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            head     <= '0;
            tail     <= '0;
            in_ready <= 1'b0;
        end else begin
            count    <= count_nxt;
            head     <= head_nxt;
            tail     <= tail_nxt;
            in_ready <= (count_nxt != 2'd2);
        end
    end

    always_comb begin
        count_nxt = count;
        head_nxt  = head;
        tail_nxt  = tail;
        case (count)
            2'd0: begin
                if (push) begin
                    head_nxt  = dec_entry;
                    count_nxt = 2'd1;
                end
            end
            2'd1: begin
                case ({push, pop})
                    2'b10: begin
                        tail_nxt  = dec_entry;
                        count_nxt = 2'd2;
                    end
                    2'b01: count_nxt = 2'd0;
                    2'b11: head_nxt  = dec_entry;
                    default: ;
                endcase
            end
            default: begin
                // Full: in_ready is low, so only a pop can happen here
                if (pop) begin
                    head_nxt  = tail;
                    count_nxt = 2'd1;
                end
            end
        endcase
    end

    always_comb begin
        out_valid = (count != 2'd0);
        out_lines = head[NUM_OUT-1:0];
        out_err   = head[NUM_OUT];
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (push && dec_err && !(&err_cnt)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
